// File: rtl/da_wave_ctrl.sv
// da_wave_ctrl: DDS playback controller feeding the AD9708 DAC.
// A phase accumulator drives the waveform ROM address. Each returned sample is
// scaled by amp, offset, saturated and then registered onto da_data.
// Optional macro DA_CTRL_SYNC_OUT_EN adds sync_out, a pulse marking samples
// whose address came from a phase wrap.
module da_wave_ctrl #(
  parameter int                 PHASE_W   = 32,
  parameter int                 ADDR_W    = 8,
  parameter int                 DATA_W    = 8,
  parameter logic [DATA_W-1:0]  IDLE_CODE = 8'h80
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_wr,
  input  logic [1:0]        cfg_addr,
  input  logic [31:0]       cfg_wdata,
  input  logic              start,
  input  logic              stop,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              da_clk,
  output logic [DATA_W-1:0] da_data,
  output logic              busy,
  output logic              done
`ifdef DA_CTRL_SYNC_OUT_EN
  ,output logic             sync_out
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH1, FLUSH2} state_t;

  state_t              state_q, state_d;
  logic [PHASE_W-1:0]  phase_q, phase_d;
  logic [PHASE_W-1:0]  ftw_q, ftw_d;
  logic [PHASE_W-1:0]  pinit_q, pinit_d;
  logic [DATA_W-1:0]   amp_q, amp_d;
  logic [DATA_W-1:0]   off_q, off_d;
  logic [15:0]         blen_q, blen_d;
  logic [15:0]         blen_lat_q, blen_lat_d;
  logic [15:0]         count_q, count_d;
  logic                wrap_q, wrap_d;       // current address came from a carry-out
  logic                rom_vld_q, rom_vld_d; // rom_data holds a sample this cycle
  logic                sync_pipe_q, sync_pipe_d;
  logic                sync_q, sync_d;
  logic [DATA_W-1:0]   da_q, da_d;

  logic [PHASE_W:0]    acc_sum;
  logic [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0]   scaled;
  logic [DATA_W+1:0]   sum;
  logic [DATA_W-1:0]   sat;
  logic                last_addr;

  // Sample datapath: optional scaling, signed offset, clamp to code range.
  always_comb begin
    acc_sum = {1'b0, phase_q} + {1'b0, ftw_q};
    prod    = {{DATA_W{1'b0}}, rom_data} * {{DATA_W{1'b0}}, amp_q};
    scaled  = (amp_q == '0) ? rom_data : prod[2*DATA_W-1:DATA_W];
    sum     = {2'b00, scaled} + {{2{off_q[DATA_W-1]}}, off_q};
    if (sum[DATA_W+1])   sat = '0;
    else if (sum[DATA_W]) sat = '1;
    else                  sat = sum[DATA_W-1:0];
  end

  // Next-state: FSM, phase/count, config registers and output pipeline.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    count_d     = count_q;
    blen_lat_d  = blen_lat_q;
    wrap_d      = wrap_q;
    ftw_d       = ftw_q;
    amp_d       = amp_q;
    off_d       = off_q;
    blen_d      = blen_q;
    pinit_d     = pinit_q;
    last_addr   = (blen_lat_q != 16'd0) && ((count_q + 16'd1) == blen_lat_q);

    if (cfg_wr) begin
      case (cfg_addr)
        2'd0: ftw_d   = cfg_wdata[PHASE_W-1:0];
        2'd1: begin
          amp_d = cfg_wdata[DATA_W-1:0];
          off_d = cfg_wdata[2*DATA_W-1:DATA_W];
        end
        2'd2: blen_d  = cfg_wdata[15:0];
        default: pinit_d = cfg_wdata[PHASE_W-1:0];
      endcase
    end

    case (state_q)
      IDLE: if (start) begin
        phase_d    = pinit_q;
        count_d    = 16'd0;
        blen_lat_d = blen_q;
        wrap_d     = 1'b0;
        state_d    = RUN;
      end
      RUN: begin
        // The address presented in the exit cycle is held through the flush.
        if (stop || last_addr) begin
          state_d = FLUSH1;
        end else begin
          phase_d = acc_sum[PHASE_W-1:0];
          wrap_d  = acc_sum[PHASE_W];
          count_d = count_q + 16'd1;
        end
      end
      FLUSH1:  state_d = FLUSH2;
      default: state_d = IDLE;
    endcase

    rom_vld_d   = (state_q == RUN);
    sync_pipe_d = (state_q == RUN) && wrap_q;
    sync_d      = rom_vld_q && sync_pipe_q;
    da_d        = rom_vld_q ? sat : IDLE_CODE;
  end

  // State register with synchronous reset; a mid-run reset drops the pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      count_q     <= '0;
      blen_lat_q  <= '0;
      wrap_q      <= 1'b0;
      ftw_q       <= '0;
      amp_q       <= '0;
      off_q       <= '0;
      blen_q      <= '0;
      pinit_q     <= '0;
      rom_vld_q   <= 1'b0;
      sync_pipe_q <= 1'b0;
      sync_q      <= 1'b0;
      da_q        <= IDLE_CODE;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      count_q     <= count_d;
      blen_lat_q  <= blen_lat_d;
      wrap_q      <= wrap_d;
      ftw_q       <= ftw_d;
      amp_q       <= amp_d;
      off_q       <= off_d;
      blen_q      <= blen_d;
      pinit_q     <= pinit_d;
      rom_vld_q   <= rom_vld_d;
      sync_pipe_q <= sync_pipe_d;
      sync_q      <= sync_d;
      da_q        <= da_d;
    end
  end

  assign rom_addr = phase_q[PHASE_W-1 -: ADDR_W];
  assign da_clk   = ~clk;
  assign da_data  = da_q;
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == FLUSH2);
`ifdef DA_CTRL_SYNC_OUT_EN
  assign sync_out = sync_q;
`endif

endmodule

// File: tb/tb_da_wave_ctrl.sv
// Self-checking bench for da_wave_ctrl: fixed vectors, hand sequences and
// randomized bursts checked against an arithmetic reference model.
module tb_da_wave_ctrl;
  logic        clk = 1'b0;
  logic        rst, cfg_wr, start, stop;
  logic [1:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic [7:0]  rom_addr, rom_data, da_data;
  logic        da_clk, busy, done;
`ifdef DA_CTRL_SYNC_OUT_EN
  logic        sync_out;
`endif

  logic [7:0] rom_mem [256];
  int pass_cnt = 0;
  int tot_cnt  = 0;

  always #5 clk = ~clk;

  // Synchronous waveform ROM: data valid one cycle after the address.
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  da_wave_ctrl dut (
    .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .start(start), .stop(stop), .rom_addr(rom_addr),
    .rom_data(rom_data), .da_clk(da_clk), .da_data(da_data), .busy(busy),
    .done(done)
`ifdef DA_CTRL_SYNC_OUT_EN
    ,.sync_out(sync_out)
`endif
  );

  typedef struct {
    logic [7:0] rom;
    logic [7:0] amp;
    logic [7:0] off;
    logic [7:0] exp;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
    cfg_wr = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_wr = 1'b0; cfg_wdata = $urandom;
  endtask

  // Reference: unity or (rom*amp)/256, plus signed offset, clamped to 0..255.
  function automatic logic [7:0] ref_sample(logic [7:0] r, logic [7:0] amp, logic [7:0] off);
    int s, y;
    s = (amp == 8'd0) ? int'(r) : (int'(r) * int'(amp)) / 256;
    y = s + int'($signed(off));
    if (y < 0) y = 0;
    if (y > 255) y = 255;
    return y[7:0];
  endfunction

  function automatic logic [31:0] ph_at(logic [31:0] pinit, logic [31:0] ftw, int k);
    return pinit + ftw * 32'(k);
  endfunction

  // Burst of n samples; checks addresses, data, done, busy (and sync_out).
  task automatic run_burst(input logic [31:0] pinit, input logic [31:0] ftw,
                           input logic [7:0] amp, input logic [7:0] off,
                           input int n, output logic [7:0] last);
    logic [31:0] junk;
    logic [7:0]  exp_da;
    logic [32:0] t;
    int k;
    junk = $urandom;
    last = 8'h00;
    cfg_write(2'd0, ftw);
    cfg_write(2'd1, {junk[31:16], off, amp});
    cfg_write(2'd2, {junk[31:16], 16'(n)});
    cfg_write(2'd3, pinit);
    start = 1'b1;
    @(negedge clk);
    chk("busy_at_start", busy, 1'b0);
    tick();
    start = 1'b0;
    for (int j = 1; j <= n + 3; j++) begin
      @(negedge clk);
      k = (j - 1 < n - 1) ? j - 1 : n - 1;
      chk("burst_addr", rom_addr, ph_at(pinit, ftw, k) >> 24);
      if (j >= 3 && j <= n + 2) begin
        exp_da = ref_sample(rom_mem[8'(ph_at(pinit, ftw, j - 3) >> 24)], amp, off);
        if (j == n + 2) last = da_data;
      end else exp_da = 8'h80;
      chk("burst_da", da_data, exp_da);
      chk("burst_done", done, j == n + 2);
      chk("burst_busy", busy, j <= n + 2);
`ifdef DA_CTRL_SYNC_OUT_EN
      if (j >= 4 && j <= n + 2) begin
        t = {1'b0, ph_at(pinit, ftw, j - 4)} + {1'b0, ftw};
        chk("sync_out", sync_out, t[32]);
      end else chk("sync_out_idle", sync_out, 1'b0);
`else
      t = '0;
`endif
      tick();
    end
  endtask

  initial begin
    vec_t        tbl [10];
    logic [7:0]  last;
    logic [31:0] exp_a [8];

    tbl[0] = '{8'hFF, 8'h80, 8'h00, 8'h7F};
    tbl[1] = '{8'hC0, 8'h00, 8'h7F, 8'hFF};
    tbl[2] = '{8'h10, 8'h00, 8'h80, 8'h00};
    tbl[3] = '{8'h40, 8'h00, 8'h00, 8'h40};
    tbl[4] = '{8'h80, 8'h40, 8'h00, 8'h20};
    tbl[5] = '{8'h80, 8'hFF, 8'h00, 8'h7F};
    tbl[6] = '{8'h10, 8'h00, 8'h10, 8'h20};
    tbl[7] = '{8'hFF, 8'hFF, 8'h81, 8'h7F};
    tbl[8] = '{8'h00, 8'h00, 8'h80, 8'h00};
    tbl[9] = '{8'hC0, 8'h80, 8'h40, 8'hA0};

    for (int i = 0; i < 256; i++) rom_mem[i] = 8'($urandom);
    rst = 1'b1; cfg_wr = 1'b0; cfg_addr = 2'd0; cfg_wdata = '0;
    start = 1'b0; stop = 1'b0;
    tick(); tick();
    @(negedge clk);
    chk("rst_addr", rom_addr, 8'h00);
    chk("rst_da", da_data, 8'h80);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    rst = 1'b0;
    tick();

    // Basic 4-sample burst and phase-wrap burst
    run_burst(32'h0, 32'h01000000, 8'h00, 8'h00, 4, last);
    run_burst(32'hC0000000, 32'h40000000, 8'h00, 8'h00, 4, last);

    // Arithmetic vectors, one single-sample burst each from ROM[0]
    for (int i = 0; i < 10; i++) begin
      rom_mem[0] = tbl[i].rom;
      run_burst(32'h0, 32'h0, tbl[i].amp, tbl[i].off, 1, last);
      chk("arith_vec", last, tbl[i].exp);
    end

    // Continuous playback; start during RUN ignored; stop on 10th RUN cycle
    cfg_write(2'd0, 32'h01000000);
    cfg_write(2'd1, 32'h0);
    cfg_write(2'd2, 32'h0);
    cfg_write(2'd3, 32'h0);
    start = 1'b1; tick(); start = 1'b0;
    for (int j = 1; j <= 13; j++) begin
      start = (j == 5);
      stop  = (j == 10);
      @(negedge clk);
      chk("cont_addr", rom_addr, (j <= 10) ? j - 1 : 9);
      chk("cont_done", done, j == 12);
      chk("cont_busy", busy, j <= 12);
      tick();
    end
    start = 1'b0; stop = 1'b0;

    // Live retune: FTW write in RUN cycle 4 changes the step applied in cycle 5
    exp_a = '{0, 1, 2, 3, 4, 6, 8, 10};
    start = 1'b1; tick(); start = 1'b0;
    for (int j = 1; j <= 11; j++) begin
      cfg_wr = (j == 4); cfg_addr = 2'd0; cfg_wdata = 32'h02000000;
      stop = (j == 8);
      @(negedge clk);
      chk("retune_addr", rom_addr, (j <= 8) ? exp_a[j-1] : 32'd10);
      chk("retune_done", done, j == 10);
      tick();
    end
    cfg_wr = 1'b0; stop = 1'b0;

    // Reset mid-playback: aborts immediately, no done pulse, registers cleared
    cfg_write(2'd0, 32'h03000000);
    cfg_write(2'd1, 32'h00000040);
    cfg_write(2'd3, 32'h55000000);
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    for (int j = 0; j < 3; j++) begin
      tick();
      @(negedge clk);
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_done", done, 1'b0);
    end
    rst = 1'b0;
    for (int j = 0; j < 4; j++) begin
      tick();
      @(negedge clk);
      chk("postrst_addr", rom_addr, 8'h00);
      chk("postrst_da", da_data, 8'h80);
      chk("postrst_busy", busy, 1'b0);
      chk("postrst_done", done, 1'b0);
    end
    // Cleared config: FTW=0, pinit=0, unity gain, zero offset, continuous
    tick();
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    @(negedge clk);
    chk("postrst_run_addr", rom_addr, 8'h00);
    chk("postrst_run_da", da_data, rom_mem[0]);
    tick();
    stop = 1'b1; tick(); stop = 1'b0;
    tick(); tick(); tick();

    // Randomized bursts against the reference model
    for (int i = 0; i < 12; i++) begin
      logic [7:0] a;
      a = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
      run_burst($urandom, $urandom, a, 8'($urandom), $urandom_range(1, 12), last);
    end

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
